// File: rtl/axis_out_requant.sv
// axis_out_requant: two-stage AXI-Stream requantizer.
// Each accumulator lane is arithmetically right-shifted with round-half-up,
// optionally ReLU'd, then saturated to a signed WORD_WIDTH result.
// Shift/ReLU are latched at packet start and held for the whole packet.
module axis_out_requant #(
  parameter int LANES          = 8,
  parameter int WORD_WIDTH_ACC = 32,
  parameter int WORD_WIDTH     = 8,
  parameter int SHIFT_BITS     = 5
) (
  input  logic                            aclk,
  input  logic                            rst,
  input  logic [SHIFT_BITS-1:0]           cfg_shift,
  input  logic                            cfg_relu,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  input  logic [LANES*WORD_WIDTH_ACC-1:0] s_axis_tdata,
  input  logic [LANES-1:0]                s_axis_tkeep,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [LANES*WORD_WIDTH-1:0]     m_axis_tdata,
  output logic [LANES-1:0]                m_axis_tkeep,
  output logic [31:0]                     stat_packets,
  output logic [31:0]                     stat_sat_beats
);

  typedef enum logic {IDLE, PKT} state_t;

  state_t state, state_next;

  logic [SHIFT_BITS-1:0] held_shift;
  logic                  held_relu;
  logic [SHIFT_BITS-1:0] eff_shift;
  logic                  eff_relu;

  logic ready1, ready2, in_fire, out_fire;

  // Stage 1 registers
  logic                            v1;
  logic [LANES*WORD_WIDTH_ACC-1:0] d1;
  logic [LANES-1:0]                k1;
  logic                            l1;
  logic [SHIFT_BITS-1:0]           sh1;
  logic                            relu1;

  // Stage 2 sideband
  logic s2_sat;

  // Combinational lane results from stage 1
  logic [LANES*WORD_WIDTH-1:0] q_data;
  logic                        q_sat;
  logic [WORD_WIDTH-1:0]       lane_y;
  logic                        lane_sat;

  assign ready2        = ~m_axis_tvalid | m_axis_tready;
  assign ready1        = ~v1 | ready2;
  assign s_axis_tready = ready1 & ~rst;
  assign in_fire       = s_axis_tvalid & s_axis_tready;
  assign out_fire      = m_axis_tvalid & m_axis_tready;

  // Round-half-up shift, ReLU and saturation of one lane; one extra bit of
  // headroom keeps the rounding add from overflowing.
  function automatic logic [WORD_WIDTH-1:0] requant_lane(
    input  logic signed [WORD_WIDTH_ACC-1:0] x,
    input  logic        [SHIFT_BITS-1:0]     s,
    input  logic                             relu,
    output logic                             sat
  );
    logic signed [WORD_WIDTH_ACC:0] t;
    logic signed [WORD_WIDTH_ACC:0] rnd;
    logic signed [WORD_WIDTH_ACC:0] hi;
    logic signed [WORD_WIDTH_ACC:0] lo;
    logic        [WORD_WIDTH-1:0]   res;
    t = {x[WORD_WIDTH_ACC-1], x};
    if (s != '0) begin
      rnd = {{WORD_WIDTH_ACC{1'b0}}, 1'b1} << (s - 1'b1);
      t   = (t + rnd) >>> s;
    end
    if (relu && t[WORD_WIDTH_ACC]) t = '0;
    hi = '0;
    hi[WORD_WIDTH-2:0] = '1;
    lo = '1;
    lo[WORD_WIDTH-2:0] = '0;
    sat = 1'b0;
    if (t > hi) begin
      res = hi[WORD_WIDTH-1:0];
      sat = 1'b1;
    end else if (t < lo) begin
      res = lo[WORD_WIDTH-1:0];
      sat = 1'b1;
    end else begin
      res = t[WORD_WIDTH-1:0];
    end
    return res;
  endfunction

  // Packet FSM next state and effective configuration selection
  always_comb begin
    state_next = state;
    eff_shift  = held_shift;
    eff_relu   = held_relu;
    case (state)
      IDLE: begin
        eff_shift = cfg_shift;
        eff_relu  = cfg_relu;
        if (in_fire && !s_axis_tlast) state_next = PKT;
      end
      PKT: begin
        if (in_fire && s_axis_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Packet FSM state and held configuration
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      held_shift <= '0;
      held_relu  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && in_fire) begin
        held_shift <= cfg_shift;
        held_relu  <= cfg_relu;
      end
    end
  end

  // Stage 1: capture the input beat with its effective configuration
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      d1    <= '0;
      k1    <= '0;
      l1    <= 1'b0;
      sh1   <= '0;
      relu1 <= 1'b0;
    end else if (ready1) begin
      v1 <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        d1    <= s_axis_tdata;
        k1    <= s_axis_tkeep;
        l1    <= s_axis_tlast;
        sh1   <= eff_shift;
        relu1 <= eff_relu;
      end
    end
  end

  // Per-lane arithmetic on the stage-1 beat; dropped lanes output zero
  always_comb begin
    q_data   = '0;
    q_sat    = 1'b0;
    lane_y   = '0;
    lane_sat = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_y = requant_lane(d1[i*WORD_WIDTH_ACC +: WORD_WIDTH_ACC], sh1, relu1, lane_sat);
      if (k1[i]) begin
        q_data[i*WORD_WIDTH +: WORD_WIDTH] = lane_y;
        q_sat = q_sat | lane_sat;
      end
    end
  end

  // Stage 2: output register, held while the sink stalls
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      s2_sat        <= 1'b0;
    end else if (ready2) begin
      m_axis_tvalid <= v1;
      if (v1) begin
        m_axis_tdata <= q_data;
        m_axis_tkeep <= k1;
        m_axis_tlast <= l1;
        s2_sat       <= q_sat;
      end
    end
  end

  // Statistics counted on output handshakes only
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      stat_packets   <= '0;
      stat_sat_beats <= '0;
    end else if (out_fire) begin
      if (m_axis_tlast) stat_packets <= stat_packets + 32'd1;
      if (s2_sat)       stat_sat_beats <= stat_sat_beats + 32'd1;
    end
  end

endmodule

// File: tb/tb_axis_out_requant.sv
// Self-checking bench for axis_out_requant: directed cases plus randomized
// traffic checked against an arithmetic reference model and scoreboard.
module tb_axis_out_requant;

  localparam int LANES = 8;
  localparam int AW    = 32;
  localparam int W     = 8;
  localparam int SB    = 5;

  logic                  aclk = 1'b0;
  logic                  rst  = 1'b1;
  logic [SB-1:0]         cfg_shift = '0;
  logic                  cfg_relu  = 1'b0;
  logic                  s_axis_tvalid = 1'b0;
  logic                  s_axis_tready;
  logic                  s_axis_tlast = 1'b0;
  logic [LANES*AW-1:0]   s_axis_tdata = '0;
  logic [LANES-1:0]      s_axis_tkeep = '0;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready = 1'b0;
  logic                  m_axis_tlast;
  logic [LANES*W-1:0]    m_axis_tdata;
  logic [LANES-1:0]      m_axis_tkeep;
  logic [31:0]           stat_packets;
  logic [31:0]           stat_sat_beats;

  always #5 aclk = ~aclk;

  axis_out_requant #(
    .LANES(LANES), .WORD_WIDTH_ACC(AW), .WORD_WIDTH(W), .SHIFT_BITS(SB)
  ) dut (
    .aclk(aclk), .rst(rst),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .stat_packets(stat_packets), .stat_sat_beats(stat_sat_beats)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    bit          sat;
  } beat_t;

  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          in_pkt   = 0;
  int          held_s   = 0;
  bit          held_r   = 0;
  int unsigned mdl_pk   = 0;
  int unsigned mdl_sat  = 0;
  bit          prev_stall = 0;
  logic [63:0] prev_data;
  logic [7:0]  prev_keep;
  logic        prev_last;
  bit          rand_rdy = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: floor((x + 2^(s-1)) / 2^s), ReLU, clamp to int8.
  function automatic void ref_beat(input logic [255:0] d, input logic [7:0] k,
                                   input int s, input bit relu,
                                   output logic [63:0] y, output bit sat);
    longint x, num, den, q, c;
    y = '0;
    sat = 0;
    for (int i = 0; i < LANES; i++) begin
      x = $signed(d[i*32 +: 32]);
      if (s == 0) q = x;
      else begin
        den = longint'(1) << s;
        num = x + den / 2;
        q = num / den;
        if ((num % den) != 0 && num < 0) q = q - 1;
      end
      if (relu && q < 0) q = 0;
      c = (q > 127) ? 127 : ((q < -128) ? -128 : q);
      if (k[i]) begin
        y[i*8 +: 8] = c[7:0];
        if (c != q) sat = 1;
      end
    end
  endfunction

  function automatic logic [255:0] pack(input int l[8]);
    logic [255:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = l[i];
    return d;
  endfunction

  // Scoreboard/monitor: sampled on the falling edge, away from updates.
  always @(negedge aclk) begin
    beat_t e;
    logic [63:0] y;
    bit sat;
    int s;
    bit r;
    if (rst) begin
      exp_q.delete();
      in_pkt = 0;
      mdl_pk = 0;
      mdl_sat = 0;
      prev_stall = 0;
    end else begin
      check("stat_packets", stat_packets, mdl_pk);
      check("stat_sat_beats", stat_sat_beats, mdl_sat);
      if (prev_stall) begin
        check("hold_valid", m_axis_tvalid, 1);
        check("hold_data", m_axis_tdata, prev_data);
        check("hold_keep", m_axis_tkeep, prev_keep);
        check("hold_last", m_axis_tlast, prev_last);
      end
      check("inflight_le2", exp_q.size() <= 2, 1);
      if (exp_q.size() == 2 && m_axis_tvalid && !m_axis_tready)
        check("full_stall_tready", s_axis_tready, 0);
      if (m_axis_tvalid && m_axis_tready) begin
        check("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", m_axis_tdata, e.data);
          check("out_keep", m_axis_tkeep, e.keep);
          check("out_last", m_axis_tlast, e.last);
          if (e.last) mdl_pk++;
          if (e.sat) mdl_sat++;
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        if (!in_pkt) begin
          held_s = cfg_shift;
          held_r = cfg_relu;
        end
        s = held_s;
        r = held_r;
        ref_beat(s_axis_tdata, s_axis_tkeep, s, r, y, sat);
        e.data = y;
        e.keep = s_axis_tkeep;
        e.last = s_axis_tlast;
        e.sat  = sat;
        exp_q.push_back(e);
        in_pkt = !s_axis_tlast;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_keep  = m_axis_tkeep;
      prev_last  = m_axis_tlast;
    end
  end

  // Random sink readiness, applied a little after the clock edge
  initial begin
    forever begin
      @(posedge aclk);
      #2;
      if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [255:0] d, input logic [7:0] k, input bit last, output int waited);
    bit hs;
    waited = 0;
    hs = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    do begin
      @(negedge aclk);
      hs = s_axis_tready;
      @(posedge aclk);
      #1;
      waited++;
    end while (!hs && waited < 200);
    check("send_handshake", hs, 1);
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  initial begin
    int lanes[8];
    logic [255:0] d;
    logic [31:0] w;
    int waited, total;

    repeat (3) @(posedge aclk);
    #1;
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_m_tkeep", m_axis_tkeep, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_stat_pk", stat_packets, 0);
    check("rst_stat_sat", stat_sat_beats, 0);
    check("rst_s_tready", s_axis_tready, 0);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    idle(1);

    // Single-beat packet, shift 2, two-cycle latency
    cfg_shift = 5'd2;
    cfg_relu  = 1'b0;
    lanes = '{1000, -1000, 255, -3, 3, 0, 127, -129};
    send(pack(lanes), 8'hFF, 1'b1, waited);
    check("lat_cycle1_valid", m_axis_tvalid, 0);
    idle(1);
    check("lat_cycle2_valid", m_axis_tvalid, 1);
    check("t1_data", m_axis_tdata, 64'hE0200001FF40807F);
    check("t1_keep", m_axis_tkeep, 8'hFF);
    check("t1_last", m_axis_tlast, 1);
    idle(2);
    check("t1_stat_pk", stat_packets, 1);
    check("t1_stat_sat", stat_sat_beats, 1);

    // ReLU with shift 0
    cfg_shift = 5'd0;
    cfg_relu  = 1'b1;
    lanes = '{-5, 5, 200, -200, 0, 127, -128, 1};
    send(pack(lanes), 8'hFF, 1'b1, waited);
    idle(1);
    check("t2_data", m_axis_tdata, 64'h01007F00007F0500);
    idle(2);
    check("t2_stat_sat", stat_sat_beats, 2);

    // Configuration held through a packet; next packet picks up the change
    cfg_shift = 5'd2;
    cfg_relu  = 1'b0;
    lanes = '{64, 64, 64, 64, 64, 64, 64, 64};
    d = pack(lanes);
    total = 0;
    send(d, 8'hFF, 1'b0, waited);
    total += waited;
    cfg_shift = 5'd4;
    for (int b = 1; b < 4; b++) begin
      send(d, 8'hFF, b == 3, waited);
      total += waited;
    end
    check("t3_throughput", total, 4);
    send(d, 8'hFF, 1'b0, waited);
    send(d, 8'hFF, 1'b1, waited);
    idle(4);
    check("t3_stat_pk", stat_packets, 4);

    // Dropped lanes are zero and never count as saturated
    cfg_shift = 5'd0;
    lanes = '{1, 1, 1, 1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
    send(pack(lanes), 8'h0F, 1'b1, waited);
    idle(1);
    check("t4_data", m_axis_tdata, 64'h0000000001010101);
    check("t4_keep", m_axis_tkeep, 8'h0F);
    idle(2);
    check("t4_stat_sat", stat_sat_beats, 2);
    check("t4_stat_pk", stat_packets, 5);

    // Randomized traffic with random backpressure
    rand_rdy = 1;
    for (int b = 0; b < 1000; b++) begin
      while ($urandom_range(0, 1) == 1) idle(1);
      for (int i = 0; i < LANES; i++) begin
        case ($urandom_range(0, 9))
          0: w = 32'h7FFFFFFF;
          1: w = 32'h80000000;
          2, 3, 4: w = $urandom();
          default: w = 32'($urandom_range(0, 600)) - 32'd300;
        endcase
        d[i*32 +: 32] = w;
      end
      cfg_shift = 5'($urandom_range(0, 15));
      cfg_relu  = 1'($urandom_range(0, 1));
      send(d, 8'($urandom()), $urandom_range(0, 3) == 0, waited);
    end
    s_axis_tvalid = 1'b0;
    rand_rdy = 0;
    @(posedge aclk);
    #3;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge aclk);
    #1;
    check("drain_empty", exp_q.size(), 0);

    // Reset with both stages full and stalled
    m_axis_tready = 1'b0;
    cfg_shift = 5'd1;
    cfg_relu  = 1'b0;
    lanes = '{100, 0, 0, 0, 0, 0, 0, 0};
    send(pack(lanes), 8'hFF, 1'b0, waited);
    send(pack(lanes), 8'hFF, 1'b0, waited);
    check("t6_full_tready", s_axis_tready, 0);
    check("t6_full_valid", m_axis_tvalid, 1);
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", m_axis_tvalid, 0);
    check("t6_rst_pk", stat_packets, 0);
    check("t6_rst_sat", stat_sat_beats, 0);
    check("t6_rst_tready", s_axis_tready, 0);
    @(posedge aclk);
    #1;
    rst = 1'b0;
    cfg_shift = 5'd3;
    m_axis_tready = 1'b1;
    idle(1);
    send(pack(lanes), 8'hFF, 1'b1, waited);
    idle(1);
    check("t6_new_shift", m_axis_tdata, 64'h000000000000000D);
    idle(3);
    check("t6_stat_pk", stat_packets, 1);
    check("t6_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
